// File: rtl/music_sequencer_pkg.sv
// rtl/music_sequencer_pkg.sv - shared length codes, rest note and FSM encoding for the music sequencer
package music_sequencer_pkg;

    localparam logic [3:0] LEN_NONE       = 4'd0;
    localparam logic [3:0] LEN_WHOLE      = 4'd1;
    localparam logic [3:0] LEN_HALF       = 4'd2;
    localparam logic [3:0] LEN_QUARTER    = 4'd3;
    localparam logic [3:0] LEN_EIGHTH     = 4'd4;
    localparam logic [3:0] LEN_DOTHALF    = 4'd5;
    localparam logic [3:0] LEN_DOTQUARTER = 4'd6;
    localparam logic [3:0] LEN_DOTEIGHTH  = 4'd7;

    localparam int NOTE_REST = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // Codes above DOTEIGHTH are not playable and terminate the song like NONE.
    function automatic logic is_end_marker(input logic [3:0] len);
        return (len == LEN_NONE) || (len > LEN_DOTEIGHTH);
    endfunction

endpackage

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - song ROM walker driving an external note timer and tone generator
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int NOTE_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W+3:0] rom_data,
    input  logic              note_change,
    output logic [3:0]        timer_length,
    output logic [NOTE_W-1:0] note,
    output logic              playing,
    output logic              song_done
);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [NOTE_W-1:0] cap_note_q, cap_note_d;
    logic [3:0]        len_q, len_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [3:0]        timer_length_q, timer_length_d;
    logic              playing_q, playing_d;
    logic              song_done_q, song_done_d;
    logic              end_of_song;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cap_note_d  = cap_note_q;
        len_d       = len_q;
        end_of_song = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    state_d = ST_FETCH;
                    ptr_d   = '0;
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD: begin
                cap_note_d = rom_data[NOTE_W+3:4];
                len_d      = rom_data[3:0];
                if (is_end_marker(rom_data[3:0])) begin
                    end_of_song = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (note_change) begin
                    if (ptr_q == '1) begin
                        end_of_song = 1'b1;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (end_of_song) begin
            if (loop_en) begin
                ptr_d   = '0;
                state_d = ST_FETCH;
            end else begin
                state_d = ST_DONE;
            end
        end

        // Abort leaves the pointer where it was so nothing advances on the same edge.
        if (stop) begin
            state_d = ST_IDLE;
            ptr_d   = ptr_q;
        end

        // Outputs are computed for the state being entered so they line up with it.
        timer_length_d = (state_d == ST_PLAY) ? len_d : LEN_NONE;
        case (state_d)
            ST_PLAY:           note_d = cap_note_d;
            ST_FETCH, ST_LOAD: note_d = note_q;
            default:           note_d = NOTE_W'(NOTE_REST);
        endcase
        playing_d   = (state_d == ST_FETCH) || (state_d == ST_LOAD) || (state_d == ST_PLAY);
        song_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            cap_note_q     <= '0;
            len_q          <= LEN_NONE;
            note_q         <= '0;
            timer_length_q <= LEN_NONE;
            playing_q      <= 1'b0;
            song_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            cap_note_q     <= cap_note_d;
            len_q          <= len_d;
            note_q         <= note_d;
            timer_length_q <= timer_length_d;
            playing_q      <= playing_d;
            song_done_q    <= song_done_d;
        end
    end

    assign rom_addr     = ptr_q;
    assign timer_length = timer_length_q;
    assign note         = note_q;
    assign playing      = playing_q;
    assign song_done    = song_done_q;

endmodule
